pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline controller for the fetch/decode/execute pipeline.
- Merges redirect requests from execute and the interrupt unit into the single jump_en/jump_addr pair consumed by the PC register.
- Merges stall sources (load-use, multi-cycle divider, bus wait) into one 2-bit hold_flag shared by the PC and pipeline DFF stages.
- Sequences post-redirect flush bubbles and interrupt entry (drain, then vector jump).

Parameters:
- AW, 64, address width of jump target paths.
- FLUSH_CYCLES, 2, bubble cycles forced after any redirect (IF/ID and ID/EX contents invalid); legal range 1..7.
- DRAIN_MAX, 31, max cycles waiting for div/bus to go idle before interrupt entry is forced; legal range 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- ex_jump_en_i  in  1  execute-stage branch/jump taken.
- ex_jump_addr_i  in  AW  execute-stage target.
- int_req_i  in  1  level interrupt request from CLINT; held until int_ack_o.
- int_vector_i  in  AW  interrupt handler address, stable while int_req_i high.
- int_ack_o  out  1  one-cycle pulse in the cycle the vector jump is issued.
- ld_use_stall_i  in  1  decode load-use hazard.
- div_busy_i  in  1  divider in multi-cycle operation.
- bus_wait_i  in  1  memory bus not ready.
- jump_en_o  out  1  redirect to PC (sampled by PC at next edge).
- jump_addr_o  out  AW  redirect target.
- hold_flag_o  out  2  00 run; 01 hold PC only; 10 hold PC + IF/ID; 11 hold PC + IF/ID + ID/EX.
- flush_o  out  1  invalidate IF/ID and ID/EX this cycle (insert NOP).

Behaviour:
- Reset: state=RUN, counters 0. All outputs are combinational functions of state and inputs. While rst=1 the interface is forced idle: jump_en_o=0, jump_addr_o=0, hold_flag_o=00, flush_o=0, int_ack_o=0.
- States: RUN, FLUSH, DRAIN, VECTOR.
- RUN:
  - ex_jump_en_i=1: jump_en_o=1, jump_addr_o=ex_jump_addr_i, flush_o=1; load flush counter with FLUSH_CYCLES-1; go FLUSH (or stay RUN if FLUSH_CYCLES=1).
  - Else int_req_i=1: go DRAIN and clear the drain counter. Hold is asserted from this cycle onward: hold_flag_o=10.
  - Else hold_flag_o = 11 if div_busy_i|bus_wait_i, else 10 if ld_use_stall_i, else 00.
- FLUSH:
  - flush_o=1, hold_flag_o=00; counter decrements and the state returns to RUN at 0.
  - A new ex_jump_en_i during FLUSH is ignored, because execute contents are already flushed.
  - int_req_i waits until RUN.
- DRAIN:
  - hold_flag_o=10 (fetch frozen); the counter increments each cycle.
  - Exit when div_busy_i=0 and bus_wait_i=0, or when the counter reaches DRAIN_MAX; go VECTOR.
  - ex_jump_en_i in DRAIN is dropped; the interrupt takes priority.
- VECTOR:
  - Lasts one cycle: jump_en_o=1, jump_addr_o=int_vector_i, int_ack_o=1, flush_o=1.
  - Then goes FLUSH, using the same counter rule as RUN.
- Priority within a cycle: rst > ex jump > interrupt > div/bus > load-use.
- jump_en_o is never high for two consecutive cycles.
- If int_req_i deasserts during DRAIN, return to RUN without int_ack_o.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum (RUN/FLUSH/DRAIN/VECTOR);
  - hold encodings HOLD_NONE=2'b00, HOLD_PC=2'b01, HOLD_IF=2'b10, HOLD_ID=2'b11, which are reused by the PC and the DFF stage.
- One sub-module: ctrl_hold_enc, the combinational priority encoder of stall inputs to hold_flag.

Test Plan:
- Reset: rst high 3 cycles with all requests high -> jump_en_o=0, hold_flag_o=00, int_ack_o=0. Release -> RUN.
- Jump: ex_jump_en_i=1, addr=64'h80 for 1 cycle -> jump_en_o=1 with addr 64'h80 that cycle, flush_o high for exactly 2 cycles (FLUSH_CYCLES=2), hold_flag_o=00 throughout.
- Stalls: ld_use_stall_i=1 -> hold_flag_o=10. Add div_busy_i=1 -> 11. Drop both -> 00. Same cycle as ex_jump_en_i=1 -> jump wins, hold 00.
- Interrupt with div busy: int_req_i=1, vector 64'h1000, div_busy_i high 5 more cycles -> hold 10 for 6 cycles, then single-cycle jump_en_o/int_ack_o to 64'h1000, then 2 flush cycles.
- Drain timeout: DRAIN_MAX=31, bus_wait_i stuck high -> VECTOR issued at cycle 32 after entry.
- Interrupt withdrawn: int_req_i low during DRAIN -> RUN, no jump, no ack.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller: FSM states, hold-flag encodings
// and counter widths used by the controller and the stall encoder.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_VECTOR = 2'd3
  } state_e;

  typedef logic [1:0] hold_t;

  // Shared with the PC register and the pipeline DFF stages
  localparam hold_t HOLD_NONE = 2'b00;
  localparam hold_t HOLD_PC   = 2'b01;
  localparam hold_t HOLD_IF   = 2'b10;
  localparam hold_t HOLD_ID   = 2'b11;

  // FLUSH_CYCLES <= 7, DRAIN_MAX <= 255
  localparam int unsigned FLUSH_CNT_W = 3;
  localparam int unsigned DRAIN_CNT_W = 8;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline controller (master) and the
// fetch/decode/execute datapath plus interrupt unit (slave).
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned AW = 64
);

  logic          ex_jump_en_i;
  logic [AW-1:0] ex_jump_addr_i;
  logic          int_req_i;
  logic [AW-1:0] int_vector_i;
  logic          int_ack_o;
  logic          ld_use_stall_i;
  logic          div_busy_i;
  logic          bus_wait_i;
  logic          jump_en_o;
  logic [AW-1:0] jump_addr_o;
  hold_t         hold_flag_o;
  logic          flush_o;

  modport master (
    input  ex_jump_en_i, ex_jump_addr_i, int_req_i, int_vector_i,
    input  ld_use_stall_i, div_busy_i, bus_wait_i,
    output int_ack_o, jump_en_o, jump_addr_o, hold_flag_o, flush_o
  );

  modport slave (
    output ex_jump_en_i, ex_jump_addr_i, int_req_i, int_vector_i,
    output ld_use_stall_i, div_busy_i, bus_wait_i,
    input  int_ack_o, jump_en_o, jump_addr_o, hold_flag_o, flush_o
  );

endinterface

// File: rtl/ctrl_hold_enc.sv
// Priority encoder of the stall sources into a hold flag:
// multi-cycle divider / bus wait freeze through ID/EX, load-use freezes IF/ID.
module ctrl_hold_enc
  import pipe_ctrl_pkg::*;
(
  input  logic  i_ld_use,
  input  logic  i_div_busy,
  input  logic  i_bus_wait,
  output hold_t o_hold_c
);

  always_comb begin
    o_hold_c = HOLD_NONE;
    if (i_div_busy || i_bus_wait) begin
      o_hold_c = HOLD_ID;
    end else if (i_ld_use) begin
      o_hold_c = HOLD_IF;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges execute/interrupt redirects into one
// jump, merges stalls into hold_flag, and sequences flush and interrupt entry.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned AW           = 64,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned DRAIN_MAX    = 31
) (
  input logic         clk,
  input logic         rst,
  pipe_ctrl_if.master bus
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_MAX - 1);
  localparam state_e                 AFTER_JUMP = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

  state_e                  r_state;
  logic [FLUSH_CNT_W-1:0]  r_flush_cnt;
  logic [DRAIN_CNT_W-1:0]  r_drain_cnt;
  logic                    r_jump_q;

  state_e                  w_state_n;
  logic [FLUSH_CNT_W-1:0]  w_flush_cnt_n;
  logic [DRAIN_CNT_W-1:0]  w_drain_cnt_n;
  hold_t                   w_stall_hold;
  hold_t                   w_hold;
  logic                    w_jump_en;
  logic [AW-1:0]           w_jump_addr;
  logic                    w_flush;
  logic                    w_ack;

  ctrl_hold_enc u_hold_enc (
    .i_ld_use   (bus.ld_use_stall_i),
    .i_div_busy (bus.div_busy_i),
    .i_bus_wait (bus.bus_wait_i),
    .o_hold_c   (w_stall_hold)
  );

  // Next state, counters and combinational outputs
  always_comb begin
    w_state_n     = r_state;
    w_flush_cnt_n = r_flush_cnt;
    w_drain_cnt_n = r_drain_cnt;
    w_hold        = HOLD_NONE;
    w_jump_en     = 1'b0;
    w_jump_addr   = '0;
    w_flush       = 1'b0;
    w_ack         = 1'b0;

    case (r_state)
      ST_RUN: begin
        // r_jump_q keeps jumps apart when FLUSH_CYCLES=1 leaves us in RUN
        if (bus.ex_jump_en_i && !r_jump_q) begin
          w_jump_en     = 1'b1;
          w_jump_addr   = bus.ex_jump_addr_i;
          w_flush       = 1'b1;
          w_flush_cnt_n = FLUSH_LOAD;
          w_state_n     = AFTER_JUMP;
        end else if (bus.int_req_i) begin
          w_hold        = HOLD_IF;
          w_drain_cnt_n = '0;
          w_state_n     = ST_DRAIN;
        end else begin
          w_hold        = w_stall_hold;
        end
      end

      ST_FLUSH: begin
        w_flush       = 1'b1;
        w_flush_cnt_n = r_flush_cnt - FLUSH_CNT_W'(1);
        if (r_flush_cnt <= FLUSH_CNT_W'(1)) begin
          w_state_n = ST_RUN;
        end
      end

      ST_DRAIN: begin
        w_hold        = HOLD_IF;
        w_drain_cnt_n = r_drain_cnt + DRAIN_CNT_W'(1);
        if (!bus.int_req_i) begin
          w_state_n = ST_RUN;
        end else if ((!bus.div_busy_i && !bus.bus_wait_i) || (r_drain_cnt >= DRAIN_LAST)) begin
          w_state_n = ST_VECTOR;
        end
      end

      ST_VECTOR: begin
        w_jump_en     = 1'b1;
        w_jump_addr   = bus.int_vector_i;
        w_ack         = 1'b1;
        w_flush       = 1'b1;
        w_flush_cnt_n = FLUSH_LOAD;
        w_state_n     = AFTER_JUMP;
      end

      default: begin
        w_state_n = ST_RUN;
      end
    endcase

    if (rst) begin
      w_hold      = HOLD_NONE;
      w_jump_en   = 1'b0;
      w_jump_addr = '0;
      w_flush     = 1'b0;
      w_ack       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
      r_drain_cnt <= '0;
      r_jump_q    <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_flush_cnt <= w_flush_cnt_n;
      r_drain_cnt <= w_drain_cnt_n;
      r_jump_q    <= w_jump_en;
    end
  end

  assign bus.jump_en_o   = w_jump_en;
  assign bus.jump_addr_o = w_jump_addr;
  assign bus.hold_flag_o = w_hold;
  assign bus.flush_o     = w_flush;
  assign bus.int_ack_o   = w_ack;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned AW = 64;
  localparam int unsigned FC = 2;
  localparam int unsigned DM = 31;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.AW(AW)) pif ();

  pipe_ctrl #(.AW(AW), .FLUSH_CYCLES(FC), .DRAIN_MAX(DM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (pif)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: bubbles still owed, drain age, pending vector, last jump
  int flush_left = 0;
  int drain_age  = 0;
  bit draining   = 1'b0;
  bit vec_next   = 1'b0;
  bit last_jump  = 1'b0;

  always @(negedge clk) begin
    logic        e_j, e_f, e_a;
    logic [1:0]  e_h;
    logic [63:0] e_addr;
    e_j = 1'b0; e_f = 1'b0; e_a = 1'b0; e_h = 2'b00; e_addr = 64'd0;
    if (rst) begin
      flush_left = 0; drain_age = 0; draining = 1'b0; vec_next = 1'b0;
    end else if (vec_next) begin
      e_j = 1'b1; e_f = 1'b1; e_a = 1'b1; e_addr = pif.int_vector_i;
      vec_next = 1'b0;
      flush_left = int'(FC) - 1;
    end else if (flush_left > 0) begin
      e_f = 1'b1;
      flush_left--;
    end else if (draining) begin
      e_h = 2'b10;
      drain_age++;
      if (!pif.int_req_i) draining = 1'b0;
      else if ((!pif.div_busy_i && !pif.bus_wait_i) || drain_age >= int'(DM)) begin
        draining = 1'b0;
        vec_next = 1'b1;
      end
    end else if (pif.ex_jump_en_i && !last_jump) begin
      e_j = 1'b1; e_f = 1'b1; e_addr = pif.ex_jump_addr_i;
      flush_left = int'(FC) - 1;
    end else if (pif.int_req_i) begin
      e_h = 2'b10;
      draining = 1'b1;
      drain_age = 0;
    end else if (pif.div_busy_i || pif.bus_wait_i) begin
      e_h = 2'b11;
    end else if (pif.ld_use_stall_i) begin
      e_h = 2'b10;
    end
    last_jump = e_j;

    check("model_jump_en", 64'(pif.jump_en_o), 64'(e_j));
    check("model_hold", 64'(pif.hold_flag_o), 64'(e_h));
    check("model_flush", 64'(pif.flush_o), 64'(e_f));
    check("model_ack", 64'(pif.int_ack_o), 64'(e_a));
    if (e_j) check("model_jump_addr", pif.jump_addr_o, e_addr);
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pif.ex_jump_en_i = 1'b0; pif.int_req_i = 1'b0;
    pif.ld_use_stall_i = 1'b0; pif.div_busy_i = 1'b0; pif.bus_wait_i = 1'b0;
  endtask

  initial begin
    int n;
    bit acked;

    // Reset with every request asserted
    rst = 1'b1;
    pif.ex_jump_en_i = 1'b1; pif.ex_jump_addr_i = 64'h80;
    pif.int_req_i = 1'b1; pif.int_vector_i = 64'h1000;
    pif.ld_use_stall_i = 1'b1; pif.div_busy_i = 1'b1; pif.bus_wait_i = 1'b1;
    repeat (3) begin
      at_sample();
      check("rst_jump_en", 64'(pif.jump_en_o), 64'd0);
      check("rst_hold", 64'(pif.hold_flag_o), 64'd0);
      check("rst_ack", 64'(pif.int_ack_o), 64'd0);
      check("rst_flush", 64'(pif.flush_o), 64'd0);
      next_cyc();
    end
    rst = 1'b0;
    idle_inputs();
    at_sample();
    check("run_idle_hold", 64'(pif.hold_flag_o), 64'd0);
    check("run_idle_jump", 64'(pif.jump_en_o), 64'd0);

    // Execute jump: one jump cycle, two flush cycles, no hold
    next_cyc();
    pif.ex_jump_en_i = 1'b1; pif.ex_jump_addr_i = 64'h80;
    at_sample();
    check("jmp_en", 64'(pif.jump_en_o), 64'd1);
    check("jmp_addr", pif.jump_addr_o, 64'h80);
    check("jmp_flush0", 64'(pif.flush_o), 64'd1);
    check("jmp_hold0", 64'(pif.hold_flag_o), 64'd0);
    next_cyc();
    pif.ex_jump_en_i = 1'b0;
    at_sample();
    check("jmp_flush1", 64'(pif.flush_o), 64'd1);
    check("jmp_no_repeat", 64'(pif.jump_en_o), 64'd0);
    check("jmp_hold1", 64'(pif.hold_flag_o), 64'd0);
    next_cyc();
    at_sample();
    check("jmp_flush_done", 64'(pif.flush_o), 64'd0);

    // Stall priorities
    next_cyc(); pif.ld_use_stall_i = 1'b1;
    at_sample(); check("stall_ld", 64'(pif.hold_flag_o), 64'd2);
    next_cyc(); pif.div_busy_i = 1'b1;
    at_sample(); check("stall_div", 64'(pif.hold_flag_o), 64'd3);
    next_cyc(); pif.ld_use_stall_i = 1'b0; pif.div_busy_i = 1'b0;
    at_sample(); check("stall_none", 64'(pif.hold_flag_o), 64'd0);
    next_cyc();
    pif.ld_use_stall_i = 1'b1; pif.div_busy_i = 1'b1;
    pif.ex_jump_en_i = 1'b1; pif.ex_jump_addr_i = 64'h200;
    at_sample();
    check("stall_vs_jump_en", 64'(pif.jump_en_o), 64'd1);
    check("stall_vs_jump_addr", pif.jump_addr_o, 64'h200);
    check("stall_vs_jump_hold", 64'(pif.hold_flag_o), 64'd0);
    next_cyc(); idle_inputs();
    next_cyc();

    // Interrupt entry while divider busy
    next_cyc();
    pif.int_req_i = 1'b1; pif.int_vector_i = 64'h1000; pif.div_busy_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) pif.div_busy_i = 1'b0;
      at_sample();
      check("irq_drain_hold", 64'(pif.hold_flag_o), 64'd2);
      check("irq_drain_nojump", 64'(pif.jump_en_o), 64'd0);
      next_cyc();
    end
    at_sample();
    check("irq_vec_jump", 64'(pif.jump_en_o), 64'd1);
    check("irq_vec_addr", pif.jump_addr_o, 64'h1000);
    check("irq_vec_ack", 64'(pif.int_ack_o), 64'd1);
    check("irq_vec_flush", 64'(pif.flush_o), 64'd1);
    next_cyc(); pif.int_req_i = 1'b0;
    at_sample();
    check("irq_post_flush", 64'(pif.flush_o), 64'd1);
    check("irq_post_ack", 64'(pif.int_ack_o), 64'd0);
    next_cyc();
    at_sample();
    check("irq_post_flush_done", 64'(pif.flush_o), 64'd0);

    // Drain timeout with bus stuck busy
    next_cyc();
    pif.int_req_i = 1'b1; pif.int_vector_i = 64'h2000; pif.bus_wait_i = 1'b1;
    n = -1;
    for (int k = 0; k < 100; k++) begin
      at_sample();
      if (pif.jump_en_o) begin
        n = k;
        break;
      end
      next_cyc();
    end
    check("timeout_cycle", 64'(n), 64'd32);
    check("timeout_ack", 64'(pif.int_ack_o), 64'd1);
    check("timeout_addr", pif.jump_addr_o, 64'h2000);
    next_cyc(); idle_inputs();
    next_cyc(); next_cyc();

    // Interrupt withdrawn during drain
    pif.int_req_i = 1'b1; pif.int_vector_i = 64'h3000; pif.div_busy_i = 1'b1;
    at_sample(); check("wd_entry_hold", 64'(pif.hold_flag_o), 64'd2);
    next_cyc(); pif.int_req_i = 1'b0;
    at_sample();
    check("wd_drain_hold", 64'(pif.hold_flag_o), 64'd2);
    check("wd_drain_ack", 64'(pif.int_ack_o), 64'd0);
    next_cyc();
    for (int k = 0; k < 4; k++) begin
      at_sample();
      check("wd_run_hold", 64'(pif.hold_flag_o), 64'd3);
      check("wd_run_jump", 64'(pif.jump_en_o), 64'd0);
      check("wd_run_ack", 64'(pif.int_ack_o), 64'd0);
      next_cyc();
    end
    idle_inputs();

    // Randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      at_sample();
      acked = pif.int_ack_o;
      next_cyc();
      rst = ($urandom_range(0, 199) == 0);
      pif.ex_jump_en_i = ($urandom_range(0, 7) == 0);
      pif.ex_jump_addr_i = {$urandom(), $urandom()};
      if (pif.int_req_i) begin
        if (acked || $urandom_range(0, 63) == 0) pif.int_req_i = 1'b0;
      end else if ($urandom_range(0, 15) == 0) begin
        pif.int_req_i = 1'b1;
        pif.int_vector_i = {$urandom(), $urandom()};
      end
      pif.ld_use_stall_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) pif.div_busy_i = ~pif.div_busy_i;
      if ($urandom_range(0, 5) == 0) pif.bus_wait_i = ~pif.bus_wait_i;
    end

    at_sample();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
